// File: rtl/bus_port_fifo.sv
// Per-driver bus port buffer: a TX FWFT FIFO feeding the bus pop handshake and an
// address-filtered RX FWFT FIFO capturing bus deliveries for this port or broadcast.
module bus_port_fifo #(
   parameter int          width = 16,
   parameter int          depth = 8,
   parameter logic [7:0]  id    = 8'd0,
   parameter logic [7:0]  bcast = 8'hFF,
   localparam int         CW    = $clog2(depth + 1),
   localparam int         PW    = $clog2(depth)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tx_push,
   input  logic [width-1:0] tx_data,
   output logic             tx_full,
   output logic [CW-1:0]    tx_count,
   output logic [7:0]       tx_ovf_cnt,
   output logic             pndng,
   output logic [width-1:0] D_pop,
   input  logic             pop,
   input  logic             push,
   input  logic [width-1:0] D_push,
   output logic             rx_valid,
   output logic [width-1:0] rx_data,
   input  logic             rx_pop,
   output logic [7:0]       rx_drop_cnt
);

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [width-1:0] tx_mem [depth];
   logic [PW-1:0]    tx_rd, tx_wr;
   logic [CW-1:0]    tx_occ;
   logic             tx_do_push, tx_do_pop, tx_drop;

   logic [width-1:0] rx_mem [depth];
   logic [PW-1:0]    rx_rd, rx_wr;
   logic [CW-1:0]    rx_occ;
   logic             rx_full, rx_match, rx_do_push, rx_do_pop, rx_drop;

   assign tx_full    = (tx_occ == CW'(depth));
   assign pndng      = (tx_occ != '0);
   assign tx_count   = tx_occ;
   assign tx_do_pop  = pop && pndng;
   // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
   assign tx_do_push = tx_push && (!tx_full || tx_do_pop);
   assign tx_drop    = tx_push && tx_full && !tx_do_pop;
   assign D_pop      = pndng ? tx_mem[tx_rd] : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_rd      <= '0;
         tx_wr      <= '0;
         tx_occ     <= '0;
         tx_ovf_cnt <= '0;
      end else begin
         if (tx_do_push) tx_wr <= tx_wr + PW'(1);
         if (tx_do_pop)  tx_rd <= tx_rd + PW'(1);
         tx_occ <= tx_occ + CW'(tx_do_push) - CW'(tx_do_pop);
         if (tx_drop) tx_ovf_cnt <= sat_inc(tx_ovf_cnt);
      end
   end

   always_ff @(posedge clk) begin
      if (tx_do_push) tx_mem[tx_wr] <= tx_data;
   end

   assign rx_full    = (rx_occ == CW'(depth));
   assign rx_valid   = (rx_occ != '0);
   assign rx_match   = push && ((D_push[width-1 -: 8] == id) || (D_push[width-1 -: 8] == bcast));
   assign rx_do_pop  = rx_pop && rx_valid;
   assign rx_do_push = rx_match && (!rx_full || rx_do_pop);
   assign rx_drop    = rx_match && rx_full && !rx_do_pop;
   assign rx_data    = rx_valid ? rx_mem[rx_rd] : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_rd       <= '0;
         rx_wr       <= '0;
         rx_occ      <= '0;
         rx_drop_cnt <= '0;
      end else begin
         if (rx_do_push) rx_wr <= rx_wr + PW'(1);
         if (rx_do_pop)  rx_rd <= rx_rd + PW'(1);
         rx_occ <= rx_occ + CW'(rx_do_push) - CW'(rx_do_pop);
         if (rx_drop) rx_drop_cnt <= sat_inc(rx_drop_cnt);
      end
   end

   always_ff @(posedge clk) begin
      if (rx_do_push) rx_mem[rx_wr] <= D_push;
   end

endmodule

// File: doc/bus_port_fifo.md
# bus_port_fifo

Per-driver port buffer that sits between a test agent (or user logic) and one port of the bus generator/arbiter `bs_gnrtr_n_rbtr`. The TX half queues outgoing packets and presents them to the bus through the `pndng`/`pop`/`D_pop` handshake. The RX half captures packets the bus delivers on `push`/`D_push`, keeps only those addressed to this port or broadcast, and buffers them for the consumer. One instance exists per driver, so the bench instantiates `drvrs` of them.

## Interface
Parameters:
- `width`, 16, packet width in bits; bits [width-1:width-8] are the destination ID.
- `depth`, 8, entries per FIFO (TX and RX each); power of two, ≥2.
- `id`, 0, this port's 8-bit address.
- `bcast`, 8'hFF, broadcast destination ID.

Ports (CW = $clog2(depth+1)):
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `tx_push`  in  1  agent writes `tx_data` into the TX FIFO.
- `tx_data`  in  width  packet to send.
- `tx_full`  out  1  TX FIFO holds `depth` entries.
- `tx_count`  out  CW  TX occupancy.
- `tx_ovf_cnt`  out  8  TX pushes dropped because the FIFO was full; saturating.
- `pndng`  out  1  TX not empty (to bus).
- `D_pop`  out  width  TX head packet (to bus).
- `pop`  in  1  bus consumes the TX head.
- `push`  in  1  bus delivers `D_push` to this port.
- `D_push`  in  width  delivered packet.
- `rx_valid`  out  1  RX not empty.
- `rx_data`  out  width  RX head packet.
- `rx_pop`  in  1  consumer removes the RX head.
- `rx_drop_cnt`  out  8  accepted-address packets dropped because RX was full; saturating.

## Operation
- Both FIFOs are circular buffers with read and write pointers of width $clog2(depth) and an occupancy counter. Pointers wrap from `depth-1` to 0.
- Both FIFOs are first-word fall-through: `D_pop` and `rx_data` show the head entry whenever `pndng` or `rx_valid` is high, and drive 0 when the FIFO is empty.
- TX write: when `tx_push` is high and the FIFO is not full, store `tx_data` and increment occupancy.
- TX full:
  - `tx_push` while full, without a same-cycle `pop`, drops the data and increments `tx_ovf_cnt`, which saturates at 255.
  - `tx_push` and `pop` in the same cycle while full: both take effect, occupancy stays `depth`, nothing is dropped.
- TX read: when `pop` is high and `pndng` is high, advance the read pointer.
  - `pop` while empty is ignored.
  - `tx_push` and `pop` in the same cycle while empty: the push is stored and the pop is ignored.
- RX accept: on `push`, compare `D_push[width-1:width-8]` with `id` and with `bcast`.
  - Match and RX not full (or `rx_pop` in the same cycle): store the packet.
  - Match and RX full with no `rx_pop`: drop the packet and increment `rx_drop_cnt`, saturating.
  - No match: ignore silently; no counter changes.
- RX read: `rx_pop` with `rx_valid` high advances the read pointer. `rx_pop` while empty is ignored.
- Ordering: strict FIFO order on each side. The TX and RX halves are fully independent.

## Timing
- Reset applies on the rising edge while `reset=1`. It clears pointers, occupancies and both counters, so:
  - `pndng`, `tx_full`, `rx_valid` = 0
  - `tx_count` = 0
  - `D_pop`, `rx_data` = 0
  - `tx_ovf_cnt`, `rx_drop_cnt` = 0
- Reset asserted mid-operation discards all queued data in the same edge.
- Inputs are ignored during any cycle in which `reset` is high.
- Latency, push to visible: `tx_push` sampled at edge N gives `pndng`=1 and `D_pop`=data after edge N, i.e. visible in cycle N+1. The RX path is the same: `push` to `rx_valid`.
- Pop: `pop` sampled at edge N presents the next head, or `pndng`=0, after edge N.
- All status outputs (`tx_full`, `tx_count`, counters) are registered or derived from registered state. There is no combinational path from any input to any output except the FWFT data mux from pointer state.
- The bus may hold `pop` high on consecutive cycles; each edge with `pndng`=1 consumes exactly one entry.

## Test plan
- Reset then idle: after 2 cycles with `reset=1`, all outputs are 0 and `pop`/`rx_pop` have no effect.
- TX fill and drain:
  - Push 0x0101..0x0108 on 8 consecutive cycles: `tx_full`=1 and `tx_count`=8.
  - A 9th push (0x0109): `tx_ovf_cnt`=1.
  - Pop 8 times: `D_pop` sequence 0x0101..0x0108, then `pndng`=0 and `D_pop`=0.
- Full plus simultaneous push/pop: with TX full, push 0x0A0A and pop in the same cycle.
  - `tx_count` stays 8 and `tx_ovf_cnt` is unchanged.
  - 0x0A0A emerges last.
- Empty plus simultaneous push/pop: push 0x1234 and pop on the same edge with TX empty: `pndng`=1 and `D_pop`=0x1234 next cycle.
- RX filter with `id`=3:
  - Deliver 0x0311, 0x0522, 0xFF33: `rx_data` yields 0x0311 then 0xFF33, and 0x0522 never appears.
  - With RX full, a further 0x0344: `rx_drop_cnt`=1.
- Wrap and reset:
  - Push and pop 20 packets interleaved (pointers wrap twice): order is preserved.
  - Assert `reset` with 5 entries queued: next cycle `pndng`=0 and `tx_count`=0.
